// File: rtl/spi1_cmd_if.sv
// Byte-stream / bus-request bundle for spi1_cmd.
// master: the command parser (drives bus requests and tx byte).
// slave : the environment (byte layer and arbiter).
interface spi1_cmd_if #(
  parameter int unsigned ADDR_WIDTH = 17
);
  logic                  cs_active_i;
  logic                  byte_strobe_i;
  logic [7:0]            rx_byte_i;
  logic [7:0]            tx_byte_o;
  logic                  req_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [7:0]            wr_data_o;
  logic                  ack_i;
  logic [7:0]            rd_data_i;
  logic                  err_o;

  modport master (
    input  cs_active_i, byte_strobe_i, rx_byte_i, ack_i, rd_data_i,
    output tx_byte_o, req_o, we_o, addr_o, wr_data_o, err_o
  );

  modport slave (
    output cs_active_i, byte_strobe_i, rx_byte_i, ack_i, rd_data_i,
    input  tx_byte_o, req_o, we_o, addr_o, wr_data_o, err_o
  );
endinterface

// File: rtl/spi1_cmd.sv
// SPI1 command parser: turns framed bytes (opcode, addr hi, addr lo, [data])
// into bus requests for the arbiter and returns read data as the next tx byte.
// Ports: clk_i, rst_ni (async active-low), bus (spi1_cmd_if.master):
//   cs_active_i/byte_strobe_i/rx_byte_i from the byte layer, tx_byte_o back,
//   req_o/we_o/addr_o/wr_data_o to the arbiter, ack_i/rd_data_i from it,
//   err_o sticky error flag.
// Optional: define SPI1_CMD_TIMEOUT_EN to add an ack watchdog of
// TIMEOUT_CYCLES cycles (the parameter exists only in that build).
module spi1_cmd #(
  parameter int unsigned ADDR_WIDTH = 17
`ifdef SPI1_CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic         clk_i,
  input logic         rst_ni,
  spi1_cmd_if.master  bus
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_ISSUE, S_WAIT_ACK, S_IGNORE
  } state_e;

  state_e                state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic                  op_next_q, op_next_d;
  logic                  cs_q;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            tx_q, tx_d;
  logic                  err_q, err_d;
  logic                  strobe;
  logic                  cs_rise;

`ifdef SPI1_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Parsing only accepts bytes inside a frame; overrun detection uses the raw strobe.
  assign strobe  = bus.byte_strobe_i & bus.cs_active_i;
  assign cs_rise = bus.cs_active_i & ~cs_q;

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_CMD;
      op_write_q <= 1'b0;
      op_next_q  <= 1'b0;
      cs_q       <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_q       <= '0;
      err_q      <= 1'b0;
`ifdef SPI1_CMD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      op_next_q  <= op_next_d;
      cs_q       <= bus.cs_active_i;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
`ifdef SPI1_CMD_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    op_next_d  = op_next_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    err_d      = err_q;
`ifdef SPI1_CMD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    // Clear at frame start; any error raised this cycle below takes priority.
    if (state_q == S_CMD && cs_rise) err_d = 1'b0;
    if (bus.byte_strobe_i && (state_q == S_ISSUE || state_q == S_WAIT_ACK)) err_d = 1'b1;

    case (state_q)
      S_CMD: begin
        if (strobe) begin
          if (bus.rx_byte_i[7]) begin
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end else begin
            op_next_d  = bus.rx_byte_i[6];
            op_write_d = bus.rx_byte_i[5];
            addr_d     = ADDR_WIDTH'({bus.rx_byte_i[0], 16'h0000});
            state_d    = S_ADDR_HI;
          end
        end
      end
      S_ADDR_HI: begin
        if (strobe) begin
          addr_d[15:8] = bus.rx_byte_i;
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (strobe) begin
          addr_d[7:0] = bus.rx_byte_i;
          state_d     = op_write_q ? S_DATA : S_ISSUE;
        end
      end
      S_DATA: begin
        if (strobe) begin
          wdata_d = bus.rx_byte_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        we_d    = op_write_q;
        state_d = S_WAIT_ACK;
`ifdef SPI1_CMD_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT_ACK: begin
        if (bus.ack_i) begin
          req_d = 1'b0;
          if (!we_q) tx_d = bus.rd_data_i;
          if (op_next_q) addr_d = addr_q + ADDR_WIDTH'(1);
          if (!bus.cs_active_i)  state_d = S_CMD;
          else if (!op_next_q)   state_d = S_IGNORE;
          else if (op_write_q)   state_d = S_DATA;
          else                   state_d = S_ISSUE;
`ifdef SPI1_CMD_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          tx_d    = 8'hFF;
          state_d = bus.cs_active_i ? S_IGNORE : S_CMD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_IGNORE: ;
      default: state_d = S_CMD;
    endcase

    // Frame end returns to CMD, except that an outstanding request must finish.
    if (!bus.cs_active_i && state_q != S_WAIT_ACK) state_d = S_CMD;
  end

  assign bus.req_o     = req_q;
  assign bus.we_o      = we_q;
  assign bus.addr_o    = addr_q;
  assign bus.wr_data_o = wdata_q;
  assign bus.tx_byte_o = tx_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_spi1_cmd.sv
// Self-checking bench for spi1_cmd: directed table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_spi1_cmd;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_tx = 8'h00;

  spi1_cmd_if #(.ADDR_WIDTH(17)) bus ();

  spi1_cmd #(
    .ADDR_WIDTH(17)
`ifdef SPI1_CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    bit              exp_req;
    bit              exp_we;
    logic [16:0]     exp_addr;
    logic [7:0]      exp_wd;
    logic [7:0]      rd;
    bit              exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t v [NV];

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input bit rq,
                              input bit we, input logic [16:0] a, input logic [7:0] wd,
                              input logic [7:0] rd, input bit er);
    vec_t r;
    r.n = n; r.b = {b3, b2, b1, b0};
    r.exp_req = rq; r.exp_we = we; r.exp_addr = a; r.exp_wd = wd; r.rd = rd; r.exp_err = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte_i     = b;
    bus.byte_strobe_i = 1'b1;
    tick();
    bus.byte_strobe_i = 1'b0;
  endtask

  task automatic start_frame();
    bus.cs_active_i = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    bus.cs_active_i = 1'b0;
    tick();
    tick();
  endtask

  // Wait for a request, check it, hold it a random while, then ack it.
  task automatic serve(input logic w, input logic [16:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input bit drop);
    int n = 0;
    while (bus.req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rise", 32'(bus.req_o), 32'd1);
    chk("we", 32'(bus.we_o), 32'(w));
    chk("addr", 32'(bus.addr_o), 32'(a));
    if (w) chk("wr_data", 32'(bus.wr_data_o), 32'(wd));
    if (drop) bus.cs_active_i = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk("req_hold", 32'(bus.req_o), 32'd1);
      chk("addr_hold", 32'(bus.addr_o), 32'(a));
    end
    bus.ack_i     = 1'b1;
    bus.rd_data_i = rd;
    tick();
    bus.ack_i     = 1'b0;
    bus.rd_data_i = 8'($urandom);
    chk("req_drop", 32'(bus.req_o), 32'd0);
    if (!w) exp_tx = rd;
    chk("tx_byte", 32'(bus.tx_byte_o), 32'(exp_tx));
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.cs_active_i   = 1'b0;
    bus.byte_strobe_i = 1'b0;
    bus.rx_byte_i     = 8'h00;
    bus.ack_i         = 1'b0;
    bus.rd_data_i     = 8'h00;

    v[0] = mk(4, 8'h21, 8'h80, 8'h00, 8'h5A, 1, 1, 17'h18000, 8'h5A, 8'h00, 0);
    v[1] = mk(3, 8'h00, 8'h12, 8'h34, 8'h00, 1, 0, 17'h01234, 8'h00, 8'hC3, 0);
    v[2] = mk(4, 8'hE0, 8'h01, 8'h02, 8'h03, 0, 0, 17'h0,     8'h00, 8'h00, 1);
    v[3] = mk(2, 8'h21, 8'h80, 8'h00, 8'h00, 0, 0, 17'h0,     8'h00, 8'h00, 0);
    v[4] = mk(4, 8'h3F, 8'hAB, 8'hCD, 8'h77, 1, 1, 17'h1ABCD, 8'h77, 8'h00, 0);
    v[5] = mk(3, 8'h1F, 8'h00, 8'h01, 8'h00, 1, 0, 17'h10001, 8'h00, 8'h3C, 0);
    v[6] = mk(1, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 17'h0,     8'h00, 8'h00, 1);

    // Reset values
    tick();
    tick();
    chk("rst_req", 32'(bus.req_o), 32'd0);
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_o), 32'd0);
    chk("rst_wd", 32'(bus.wr_data_o), 32'd0);
    chk("rst_tx", 32'(bus.tx_byte_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      start_frame();
      for (int j = 0; j < v[i].n; j++) begin
        send_byte(v[i].b[2'(j)]);
        if (j < v[i].n - 1) repeat ($urandom_range(0, 1)) tick();
      end
      if (v[i].exp_req) begin
        chk("latency_1", 32'(bus.req_o), 32'd0);
        tick();
        chk("latency_2", 32'(bus.req_o), 32'd1);
        serve(v[i].exp_we, v[i].exp_addr, v[i].exp_wd, v[i].rd, 1'b0);
      end else begin
        repeat (4) begin
          tick();
          chk("no_req", 32'(bus.req_o), 32'd0);
        end
      end
      chk("row_err", 32'(bus.err_o), 32'(v[i].exp_err));
      end_frame();
      chk("tx_hold", 32'(bus.tx_byte_o), 32'(exp_tx));
    end

    // READ_NEXT wrap with prefetch; CS drops while the 4th read is pending
    start_frame();
    send_byte(8'h41); send_byte(8'hFF); send_byte(8'hFF);
    serve(1'b0, 17'h1FFFF, 8'h00, 8'h11, 1'b0);
    serve(1'b0, 17'h00000, 8'h00, 8'h22, 1'b0);
    serve(1'b0, 17'h00001, 8'h00, 8'h33, 1'b0);
    serve(1'b0, 17'h00002, 8'h00, 8'h44, 1'b1);
    tick();
    chk("rn_no_req", 32'(bus.req_o), 32'd0);
    end_frame();

    // Overrun during WAIT_ACK sets err, next frame start clears it
    start_frame();
    send_byte(8'h21); send_byte(8'h00); send_byte(8'h05); send_byte(8'h5A);
    tick();
    send_byte(8'h99);
    chk("ovr_err", 32'(bus.err_o), 32'd1);
    serve(1'b1, 17'h10005, 8'h5A, 8'h00, 1'b0);
    end_frame();
    start_frame();
    chk("ovr_err_clr", 32'(bus.err_o), 32'd0);
    end_frame();

    // WRITE_NEXT: strobe coincident with ack is dropped as overrun
    start_frame();
    send_byte(8'h61); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAA);
    tick();
    chk("wn_req", 32'(bus.req_o), 32'd1);
    chk("wn_addr", 32'(bus.addr_o), 32'h10010);
    bus.ack_i = 1'b1; bus.byte_strobe_i = 1'b1; bus.rx_byte_i = 8'hBB;
    tick();
    bus.ack_i = 1'b0; bus.byte_strobe_i = 1'b0;
    chk("wn_req_drop", 32'(bus.req_o), 32'd0);
    chk("wn_err", 32'(bus.err_o), 32'd1);
    repeat (3) begin
      tick();
      chk("wn_dropped", 32'(bus.req_o), 32'd0);
    end
    send_byte(8'hCC);
    serve(1'b1, 17'h10011, 8'hCC, 8'h00, 1'b0);
    end_frame();

`ifdef SPI1_CMD_TIMEOUT_EN
    // Watchdog: READ with no ack
    begin
      int c = 0;
      start_frame();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h09);
      tick();
      chk("to_req", 32'(bus.req_o), 32'd1);
      while (bus.req_o === 1'b1 && c < 100) begin
        tick();
        c++;
      end
      chk("to_len", 32'(c), 32'd16);
      chk("to_err", 32'(bus.err_o), 32'd1);
      exp_tx = 8'hFF;
      chk("to_tx", 32'(bus.tx_byte_o), 32'hFF);
      end_frame();
    end
`endif

    // Randomized frames against a frame-level model
    for (int f = 0; f < 40; f++) begin
      int          typ;
      int          n;
      logic [16:0] base;
      logic [7:0]  op;
      typ  = int'($urandom_range(0, 3));
      base = 17'($urandom);
      op   = {3'(typ), 4'($urandom), base[16]};
      n    = (typ >= 2) ? int'($urandom_range(1, 4)) : 1;
      start_frame();
      chk("rnd_err_start", 32'(bus.err_o), 32'd0);
      send_byte(op);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(base[15:8]);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(base[7:0]);
      for (int i = 0; i < n; i++) begin
        logic [16:0] a;
        logic [7:0]  d;
        a = 17'(int'(base) + i);
        d = 8'($urandom);
        if (typ[0]) begin
          repeat ($urandom_range(0, 2)) tick();
          send_byte(d);
          serve(1'b1, a, d, 8'h00, 1'b0);
        end else begin
          serve(1'b0, a, 8'h00, d, (typ == 2) && (i == n - 1));
        end
      end
      chk("rnd_err", 32'(bus.err_o), 32'd0);
      end_frame();
      chk("rnd_tx_hold", 32'(bus.tx_byte_o), 32'(exp_tx));
    end

    // Async reset mid-WAIT_ACK with err set
    start_frame();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    tick();
    send_byte(8'h55);
    chk("pre_rst_req", 32'(bus.req_o), 32'd1);
    chk("pre_rst_err", 32'(bus.err_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.req_o), 32'd0);
    chk("arst_we", 32'(bus.we_o), 32'd0);
    chk("arst_addr", 32'(bus.addr_o), 32'd0);
    chk("arst_wd", 32'(bus.wr_data_o), 32'd0);
    chk("arst_tx", 32'(bus.tx_byte_o), 32'd0);
    chk("arst_err", 32'(bus.err_o), 32'd0);
    bus.cs_active_i = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_tx = 8'h00;
    tick();
    start_frame();
    send_byte(8'h21); send_byte(8'h00); send_byte(8'h03); send_byte(8'h3C);
    serve(1'b1, 17'h10003, 8'h3C, 8'h00, 1'b0);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi1_cmd.md
Name: spi1_cmd

Overview:
- Clock-domain consumer of the SPI1 peripheral byte stream.
- Parses framed commands (opcode, address hi, address lo, optional data) into single-cycle-per-beat bus requests for the memory/register arbiter.
- Returns read data as the next transmit byte.
- Sits between the spi1 byte layer (already synchronized into clk_i) and the bus arbiter.

Parameters:
ADDR_WIDTH, 17, bus address width; bit 16 is taken from opcode bit 0, bits 15:0 from the two address bytes.
TIMEOUT_CYCLES, 255, ack watchdog limit in clk_i cycles; used only with SPI1_CMD_TIMEOUT_EN.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
cs_active_i  input  1  synchronized CS asserted (high = frame in progress)
byte_strobe_i  input  1  one-cycle pulse: new received byte on rx_byte_i
rx_byte_i  input  8  received byte, valid with byte_strobe_i
tx_byte_o  output  8  byte to load for next SPI transfer
req_o  output  1  bus request, held until ack_i
we_o  output  1  1 = write, 0 = read; valid while req_o
addr_o  output  ADDR_WIDTH  bus address; valid while req_o
wr_data_o  output  8  write data; valid while req_o
ack_i  input  1  one-cycle completion pulse from arbiter
rd_data_i  input  8  read data, valid with ack_i when we_o = 0
err_o  output  1  sticky error flag

Behaviour:
- Reset (rst_ni low, asynchronous): state = CMD; req_o, we_o, err_o = 0; addr_o, wr_data_o, tx_byte_o = 0.
- Opcode byte bits [7:5]:
  - 000 READ
  - 001 WRITE
  - 010 READ_NEXT
  - 011 WRITE_NEXT
  - Bit 0 = A16. Bits 4:1 are ignored.
  - Any other opcode: set err_o; go to IGNORE.
- States:
  - CMD: on strobe, latch opcode and A16 -> ADDR_HI.
  - ADDR_HI: on strobe, latch A15:8 -> ADDR_LO.
  - ADDR_LO: on strobe, latch A7:0. Read opcodes -> ISSUE. Write opcodes -> DATA.
  - DATA: on strobe, latch wr_data_o -> ISSUE.
  - ISSUE: assert req_o next cycle -> WAIT_ACK.
  - WAIT_ACK: hold req_o, we_o, addr_o, wr_data_o stable until ack_i. On ack: drop req_o the same edge. For reads, tx_byte_o <= rd_data_i.
    - READ/WRITE -> IGNORE.
    - READ_NEXT/WRITE_NEXT: addr_o <= addr_o + 1, wrapping modulo 2^ADDR_WIDTH (0x1FFFF -> 0x00000).
      - READ_NEXT -> ISSUE, i.e. auto-prefetch the next read.
      - WRITE_NEXT -> DATA.
  - IGNORE: strobes are discarded until the frame ends.
- Latency: strobe of the final frame byte -> req_o high after exactly 2 clk_i cycles. ack_i -> tx_byte_o updated after 1 cycle.
- Frame end: cs_active_i low in any state -> CMD on the next edge.
  - If req_o is high at that point, the request is completed first: stay in WAIT_ACK until ack_i, then go to CMD.
  - The bus cycle is never abandoned mid-handshake.
- Overrun: byte_strobe_i while in ISSUE or WAIT_ACK -> byte dropped, err_o set.
- Simultaneous ack_i and byte_strobe_i in WAIT_ACK of WRITE_NEXT: the strobe is an overrun, err_o is set, and the byte is dropped.
- err_o clears only when cs_active_i rises while in CMD, i.e. at the start of a new frame. If err_o is set in the same cycle as that rise, it stays set.
- ack_i outside WAIT_ACK is ignored.
- tx_byte_o holds its value across frames until the next read ack.

Optional Feature:
SPI1_CMD_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter runs in WAIT_ACK and clears on entering ISSUE.
  - On reaching TIMEOUT_CYCLES without ack_i: drop req_o, set err_o, tx_byte_o <= 8'hFF, state -> IGNORE (or CMD if cs_active_i is low).
  - The counter resets asynchronously with rst_ni.
- Undefined: no counter; WAIT_ACK waits indefinitely for ack_i.

Test Plan:
- Write: frame 0x21,0x80,0x00,0x5A -> req_o/we_o=1, addr_o=0x18000, wr_data_o=0x5A, req_o high 2 cycles after 4th strobe. ack_i -> req_o low; err_o=0.
- Read: 0x00,0x12,0x34, arbiter acks with rd_data_i=0xC3 -> req_o we_o=0 addr_o=0x01234; tx_byte_o=0xC3 one cycle after ack.
- READ_NEXT wrap: 0x41,0xFF,0xFF; ack three times with 0x11,0x22,0x33 -> addr_o sequence 0x1FFFF, 0x00000, 0x00001. tx_byte_o follows 0x11, 0x22, 0x33.
- Abort and overrun:
  - cs_active_i dropped after 2 bytes -> state CMD, no req_o; a following full WRITE frame executes normally.
  - A strobe during WAIT_ACK -> err_o=1, which clears on the next frame start.
- Bad opcode 0xE0 followed by 3 bytes -> err_o=1, no req_o, remaining bytes ignored until CS is released.
- With SPI1_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: READ with no ack_i -> req_o drops after 16 cycles, err_o=1, tx_byte_o=0xFF. Also assert rst_ni low mid-WAIT_ACK -> all outputs return to their reset values immediately.
